tc77_access_arbiter: RTL and testbench
======================================

# tc77_access_arbiter

Shares the single TC77 temperature-sensor reader (TempLoader) between two requesters: requester 0 is the startup-delay/fan controller, requester 1 is the status/host poller. Grants alternate round-robin, and each grant runs one load transaction. Completed readings are returned with a per-requester acknowledge pulse. A recent valid reading can be served from an internal cache without touching the sensor. A watchdog returns an error if the loader never completes.

## Interface
Parameters:
- TIMEOUT_CYC, 24'd1_000_000: MCLK cycles allowed in WAIT before a timeout.
- CACHE_CYC, 24'd4_000_000: maximum cache age, in MCLK cycles, for a cache hit. 0 disables the cache.

Ports:
- MCLK  in  1  system clock; all logic on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- nREQ0  in  1  requester 0 read request; active low; level.
- nREQ1  in  1  requester 1 read request; active low; level.
- nACK0  out  1  one-cycle low pulse; result valid for requester 0.
- nACK1  out  1  one-cycle low pulse; result valid for requester 1.
- RDDATA  out  14  last latched TEMPDATA; held between latches.
- RDERR  out  1  valid with nACKx; 1 = timeout, RDDATA stale.
- RDCACHED  out  1  valid with nACKx; 1 = served from cache.
- BUSY  out  1  high in any state other than IDLE.
- nLOAD  out  1  to TempLoader; one-cycle low pulse starts a read.
- nCOMPLETE  in  1  from TempLoader; low = TEMPDATA valid.
- TEMPDATA  in  14  TempLoader data; bit13 = sign, bit0 = conversion-done flag.

## Operation
- Reset values: nACK0=nACK1=1, nLOAD=1, RDDATA=0, RDERR=0, RDCACHED=0, BUSY=0. Also state=IDLE, cache invalid, age=0, timeout counter=0, last-served=1 (so requester 0 wins the first tie).
- Requester rule: hold nREQx low until nACKx is sampled low. Deassert nREQx on that same edge.

State machine:
- IDLE:
  - No request: stay in IDLE.
  - One request: that requester is the winner.
  - Both requesting: the winner is the requester not served last.
  - If the cache is valid and age < CACHE_CYC: go to ACK, with RDCACHED=1 and RDERR=0. RDDATA is unchanged.
  - Otherwise: nLOAD<=0, timeout counter<=0, go to LOAD.
- LOAD: nLOAD<=1; go to WAIT.
- WAIT:
  - nCOMPLETE sampled low: RDDATA<=TEMPDATA, RDERR<=0, RDCACHED<=0, go to ACK.
    - If TEMPDATA[0]=1: cache<=valid, age<=0. Otherwise cache<=invalid.
  - Counter reaches TIMEOUT_CYC-1: RDERR<=1, RDCACHED<=0, cache<=invalid, go to ACK. RDDATA is unchanged.
  - Otherwise the counter increments.
- ACK:
  - The winner's nACK is 0 for exactly this cycle. It is registered on entry and released on exit.
  - last-served<=winner; go to IDLE.
- Age counter: increments every cycle while the cache is valid. It saturates at 2^24-1 and never wraps.
- A grant is not revoked if the winner's nREQ rises mid-transaction. The transaction completes and nACK is still pulsed.
- nCOMPLETE low outside WAIT is ignored; a late completion after a timeout is dropped.
- nACK0 and nACK1 are never low in the same cycle.
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronous). nLOAD goes high without completing the pulse. The cache is invalidated.

## Timing
- Miss path:
  - Edge E0: IDLE samples the request; nLOAD low from E0.
  - E1: LOAD; nLOAD high.
  - E2 onward: WAIT.
  - Edge Ek: first sample of nCOMPLETE=0; RDDATA updates and nACK goes low from Ek.
  - Ek+1: nACK high, IDLE.
  - Ek+2: the next grant can be decided.
- Hit path: request sampled at E0, nACK low from E0 to E1. The next grant is at E2.
- Timeout: nACK goes low TIMEOUT_CYC+1 edges after the nLOAD edge.
- nLOAD pulse width: exactly 1 cycle. At most one transaction is outstanding.

## Test plan
- Single miss, CACHE_CYC=0:
  - Stimulus: nREQ0 low; loader asserts nCOMPLETE 10 cycles after nLOAD with TEMPDATA=14'h0C81.
  - Required: one nLOAD pulse; nACK0 low 1 cycle; RDDATA=14'h0C81; RDERR=0; RDCACHED=0; nACK1 stays high.
- Simultaneous requests after reset, both held:
  - Grant order: 0, 1, 0. Exactly three nLOAD pulses across three transactions.
  - nACK0 and nACK1 never overlap.
- Cache hit, CACHE_CYC=100:
  - Stimulus: read returns bit0=1; nREQ1 asserted 20 cycles later.
  - Required: nACK1 with RDCACHED=1 and the same RDDATA; no nLOAD pulse.
  - Stimulus: nREQ1 asserted again after 150 cycles.
  - Required: a real load.
- Timeout, TIMEOUT_CYC=50, nCOMPLETE held high:
  - Required: nACK0 at nLOAD edge +51; RDERR=1; RDDATA unchanged.
  - A later nCOMPLETE pulse while in IDLE produces no acknowledge.
- Not-converted data: TEMPDATA=14'h0C80 (bit0=0).
  - Required: acknowledged with RDERR=0.
  - The following request within CACHE_CYC performs a real load.
- Async reset during WAIT:
  - Required: all outputs go to their reset values within the same cycle; BUSY=0.
  - The next request performs a load; it is not served from the cache.

Source files
------------

// File: rtl/tc77_access_arbiter.sv
// TC77 reader arbiter: round-robin sharing of the TempLoader between
// two requesters, with a reading cache and a completion watchdog.
`timescale 1ns/1ps
module tc77_access_arbiter #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000,
    parameter logic [23:0] CACHE_CYC   = 24'd4_000_000
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        nREQ0,
    input  logic        nREQ1,
    output logic        nACK0,
    output logic        nACK1,
    output logic [13:0] RDDATA,
    output logic        RDERR,
    output logic        RDCACHED,
    output logic        BUSY,
    output logic        nLOAD,
    input  logic        nCOMPLETE,
    input  logic [13:0] TEMPDATA
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [23:0] AGE_MAX = 24'hFF_FFFF;

    state_t      state, state_n;
    logic        winner, winner_n;
    logic        last_srv, last_srv_n;
    logic        cache_vld, cache_vld_n;
    logic [23:0] age, age_n;
    logic [23:0] tmo, tmo_n;
    logic        nack0_n, nack1_n, nload_n;
    logic [13:0] rddata_n;
    logic        rderr_n, rdcached_n;

    logic        req0, req1, pick, hit;

    assign req0 = ~nREQ0;
    assign req1 = ~nREQ1;
    // on a tie the requester not served last wins
    assign pick = (req0 & req1) ? ~last_srv : req1;
    assign hit  = cache_vld && (age < CACHE_CYC);
    assign BUSY = (state != S_IDLE);

    // state and registered outputs
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= S_IDLE;
            winner    <= 1'b0;
            last_srv  <= 1'b1;
            cache_vld <= 1'b0;
            age       <= '0;
            tmo       <= '0;
            nACK0     <= 1'b1;
            nACK1     <= 1'b1;
            nLOAD     <= 1'b1;
            RDDATA    <= '0;
            RDERR     <= 1'b0;
            RDCACHED  <= 1'b0;
        end else begin
            state     <= state_n;
            winner    <= winner_n;
            last_srv  <= last_srv_n;
            cache_vld <= cache_vld_n;
            age       <= age_n;
            tmo       <= tmo_n;
            nACK0     <= nack0_n;
            nACK1     <= nack1_n;
            nLOAD     <= nload_n;
            RDDATA    <= rddata_n;
            RDERR     <= rderr_n;
            RDCACHED  <= rdcached_n;
        end
    end

    // next-state, grant, cache and watchdog logic
    always_comb begin
        state_n     = state;
        winner_n    = winner;
        last_srv_n  = last_srv;
        cache_vld_n = cache_vld;
        age_n       = age;
        tmo_n       = tmo;
        nack0_n     = nACK0;
        nack1_n     = nACK1;
        nload_n     = nLOAD;
        rddata_n    = RDDATA;
        rderr_n     = RDERR;
        rdcached_n  = RDCACHED;

        if (cache_vld && age != AGE_MAX) begin
            age_n = age + 24'd1;
        end

        unique case (state)
            S_IDLE: begin
                if (req0 | req1) begin
                    winner_n = pick;
                    if (hit) begin
                        state_n    = S_ACK;
                        rdcached_n = 1'b1;
                        rderr_n    = 1'b0;
                        nack0_n    = pick;
                        nack1_n    = ~pick;
                    end else begin
                        state_n = S_LOAD;
                        nload_n = 1'b0;
                        tmo_n   = '0;
                    end
                end
            end
            S_LOAD: begin
                nload_n = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (!nCOMPLETE) begin
                    state_n    = S_ACK;
                    rddata_n   = TEMPDATA;
                    rderr_n    = 1'b0;
                    rdcached_n = 1'b0;
                    nack0_n    = winner;
                    nack1_n    = ~winner;
                    // bit0 clear means the conversion was not finished
                    cache_vld_n = TEMPDATA[0];
                    if (TEMPDATA[0]) begin
                        age_n = '0;
                    end
                end else if (tmo == TIMEOUT_CYC - 24'd1) begin
                    state_n     = S_ACK;
                    rderr_n     = 1'b1;
                    rdcached_n  = 1'b0;
                    cache_vld_n = 1'b0;
                    nack0_n     = winner;
                    nack1_n     = ~winner;
                end else begin
                    tmo_n = tmo + 24'd1;
                end
            end
            S_ACK: begin
                nack0_n    = 1'b1;
                nack1_n    = 1'b1;
                last_srv_n = winner;
                state_n    = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tc77_access_arbiter.sv
// Scoreboard bench for tc77_access_arbiter with a behavioural
// TempLoader model and directed requester sequences.
`timescale 1ns/1ps
module tb_tc77_access_arbiter;

    logic        MCLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        nREQ0 = 1'b1;
    logic        nREQ1 = 1'b1;
    logic        nCOMPLETE = 1'b1;
    logic [13:0] TEMPDATA = '0;
    logic        nACK0, nACK1, RDERR, RDCACHED, BUSY, nLOAD;
    logic [13:0] RDDATA;

    tc77_access_arbiter #(
        .TIMEOUT_CYC(24'd50),
        .CACHE_CYC  (24'd100)
    ) dut (
        .MCLK     (MCLK),
        .nRESET   (nRESET),
        .nREQ0    (nREQ0),
        .nREQ1    (nREQ1),
        .nACK0    (nACK0),
        .nACK1    (nACK1),
        .RDDATA   (RDDATA),
        .RDERR    (RDERR),
        .RDCACHED (RDCACHED),
        .BUSY     (BUSY),
        .nLOAD    (nLOAD),
        .nCOMPLETE(nCOMPLETE),
        .TEMPDATA (TEMPDATA)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        int          id;
        logic [13:0] data;
        logic        err;
        logic        cached;
        int          lat;
    } exp_t;

    exp_t        q[$];
    exp_t        e_m;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          loads = 0;
    int          load_cyc = 0;
    int          l0;
    bit          prev_load_low = 1'b0;
    bit          ld_en = 1'b1;
    int          ld_delay = 3;
    logic [13:0] ld_data = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input logic [13:0] d,
                        input logic err, input logic c, input int lat);
        exp_t x;
        x.id = id; x.data = d; x.err = err; x.cached = c; x.lat = lat;
        q.push_back(x);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_nack0"}, nACK0, 1);
        chk({tag, "_nack1"}, nACK1, 1);
        chk({tag, "_nload"}, nLOAD, 1);
        chk({tag, "_rddata"}, RDDATA, 0);
        chk({tag, "_rderr"}, RDERR, 0);
        chk({tag, "_rdcached"}, RDCACHED, 0);
        chk({tag, "_busy"}, BUSY, 0);
    endtask

    task automatic do_reset();
        nREQ0 = 1'b1;
        nREQ1 = 1'b1;
        nRESET = 1'b0;
        repeat (2) @(posedge MCLK);
        #1 nRESET = 1'b1;
    endtask

    // hold the request until the acknowledge is seen, release next edge
    task automatic do_req(input int id);
        bit got;
        got = 1'b0;
        if (id == 0) nREQ0 = 1'b0;
        else nREQ1 = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge MCLK);
            if ((id == 0 && !nACK0) || (id == 1 && !nACK1)) got = 1'b1;
        end
        chk("req_ack_timeout", got, 1);
        @(posedge MCLK);
        #1;
        if (id == 0) nREQ0 = 1'b1;
        else nREQ1 = 1'b1;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && q.size() != 0; n++) @(posedge MCLK);
        chk("drain", q.size(), 0);
        repeat (2) @(posedge MCLK);
        #1;
    endtask

    always @(posedge MCLK) cyc <= cyc + 1;

    // TempLoader model: completes ld_delay cycles after each nLOAD
    always begin
        @(negedge MCLK);
        if (nRESET && !nLOAD && ld_en) begin
            repeat (ld_delay) @(posedge MCLK);
            #1;
            TEMPDATA = ld_data;
            nCOMPLETE = 1'b0;
            @(posedge MCLK);
            #1 nCOMPLETE = 1'b1;
        end
    end

    // monitor: counts loads and pops the scoreboard on each acknowledge
    always @(negedge MCLK) begin
        if (nRESET) begin
            if (!nLOAD) begin
                chk("nload_width", prev_load_low, 0);
                loads++;
                load_cyc = cyc;
            end
            prev_load_low = !nLOAD;
            if (!nACK0 || !nACK1) begin
                chk("ack_overlap", !nACK0 && !nACK1, 0);
                if (q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e_m = q.pop_front();
                    chk("ack_id", nACK0 ? 1 : 0, e_m.id);
                    chk("rddata", RDDATA, e_m.data);
                    chk("rderr", RDERR, e_m.err);
                    chk("rdcached", RDCACHED, e_m.cached);
                    if (e_m.lat >= 0)
                        chk("latency", cyc - load_cyc, e_m.lat);
                end
            end
        end else begin
            prev_load_low = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk_reset("reset");
        @(posedge MCLK);
        #1 nRESET = 1'b1;

        // single miss
        ld_delay = 10;
        ld_data = 14'h0C81;
        l0 = loads;
        push(0, 14'h0C81, 0, 0, 11);
        do_req(0);
        drain();
        chk("miss_loads", loads - l0, 1);

        // simultaneous requests, both held: order 0,1,0
        do_reset();
        ld_delay = 3;
        ld_data = 14'h0C80;
        l0 = loads;
        push(0, 14'h0C80, 0, 0, 4);
        push(1, 14'h0C80, 0, 0, 4);
        push(0, 14'h0C80, 0, 0, 4);
        fork
            begin
                do_req(0);
                do_req(0);
            end
            do_req(1);
        join
        drain();
        chk("rr_loads", loads - l0, 3);

        // cache hit then expiry
        do_reset();
        ld_delay = 4;
        ld_data = 14'h0C81;
        push(0, 14'h0C81, 0, 0, 5);
        do_req(0);
        repeat (20) @(posedge MCLK);
        #1;
        l0 = loads;
        push(1, 14'h0C81, 0, 1, -1);
        do_req(1);
        drain();
        chk("hit_loads", loads - l0, 0);
        repeat (150) @(posedge MCLK);
        #1;
        ld_data = 14'h0D01;
        l0 = loads;
        push(1, 14'h0D01, 0, 0, 5);
        do_req(1);
        drain();
        chk("expired_loads", loads - l0, 1);

        // not-converted data is never cached
        do_reset();
        ld_data = 14'h0C80;
        push(0, 14'h0C80, 0, 0, 5);
        do_req(0);
        l0 = loads;
        push(0, 14'h0C80, 0, 0, 5);
        do_req(0);
        drain();
        chk("noconv_loads", loads - l0, 1);

        // timeout with stale data, late completion dropped
        ld_en = 1'b0;
        push(0, 14'h0C80, 1, 0, 51);
        do_req(0);
        drain();
        TEMPDATA = 14'h3FFF;
        nCOMPLETE = 1'b0;
        @(posedge MCLK);
        #1 nCOMPLETE = 1'b1;
        repeat (5) @(posedge MCLK);
        #1;
        chk("late_rddata", RDDATA, 14'h0C80);
        chk("late_busy", BUSY, 0);

        // asynchronous reset during WAIT
        do_reset();
        ld_en = 1'b1;
        ld_data = 14'h0C81;
        push(0, 14'h0C81, 0, 0, 5);
        do_req(0);
        repeat (110) @(posedge MCLK);
        #1;
        ld_en = 1'b0;
        nREQ0 = 1'b0;
        repeat (6) @(posedge MCLK);
        #2;
        chk("wait_busy", BUSY, 1);
        nREQ0 = 1'b1;
        nRESET = 1'b0;
        #1;
        chk_reset("async");
        @(posedge MCLK);
        #1 nRESET = 1'b1;
        ld_en = 1'b1;
        ld_data = 14'h0D01;
        l0 = loads;
        push(0, 14'h0D01, 0, 0, 5);
        do_req(0);
        drain();
        chk("post_reset_loads", loads - l0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
